// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor: 2**IDX_W saturating counters indexed by PC[IDX_W+1:2].
// Optional BP_STATS_EN adds saturating branch/mispredict statistics outputs.
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        pred_req,
    input  logic [31:0] pred_pc,
    output logic        pred_ready,
    output logic        pred_valid,
    output logic        pred_taken,
    input  logic        res_valid,
    input  logic [3:0]  res_type,
    input  logic        res_taken,
    output logic        mispredict,
    output logic        correct_taken
`ifdef BP_STATS_EN
    ,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispred
`endif
);

    localparam int ENTRIES = 2 ** IDX_W;

    typedef enum logic {IDLE, WAIT_RES} state_t;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up) return (c == {CTR_W{1'b1}}) ? c : c + 1'b1;
        else    return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   ctr_q [ENTRIES];
    logic [IDX_W-1:0]   pend_idx_q;
    logic               pend_pred_q;
    logic               pred_valid_q, pred_taken_q;
    logic               mispredict_q, correct_taken_q;

    logic [IDX_W-1:0]   req_idx;
    logic               qual_res;
    logic               accept;
    logic [CTR_W-1:0]   upd_ctr;
    logic [CTR_W-1:0]   lookup_ctr;
    logic               lookup_pred;
    logic               mispredict_d;
    logic               unused_pc_bits;

    assign req_idx        = pred_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    assign qual_res   = (state_q == WAIT_RES) && res_valid && (res_type != 4'd0);
    assign pred_ready = (state_q == IDLE) || qual_res;
    assign accept     = pred_req && pred_ready;

    // Same-cycle lookup of the entry being trained sees the post-update value.
    assign upd_ctr     = ctr_step(ctr_q[pend_idx_q], res_taken);
    assign lookup_ctr  = (qual_res && (req_idx == pend_idx_q)) ? upd_ctr : ctr_q[req_idx];
    assign lookup_pred = lookup_ctr[CTR_W-1];

    assign mispredict_d = qual_res && (res_taken != pend_pred_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = WAIT_RES;
            WAIT_RES: if (qual_res && !accept) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q         <= IDLE;
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            mispredict_q    <= 1'b0;
            correct_taken_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_W'(1);
        end else begin
            state_q         <= state_d;
            pred_valid_q    <= accept;
            pred_taken_q    <= accept && lookup_pred;
            mispredict_q    <= mispredict_d;
            correct_taken_q <= qual_res && res_taken;
            if (qual_res) ctr_q[pend_idx_q] <= upd_ctr;
        end
    end

    // Outstanding-prediction record; only meaningful while in WAIT_RES.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_idx_q  <= req_idx;
            pend_pred_q <= lookup_pred;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign mispredict    = mispredict_q;
    assign correct_taken = correct_taken_q;

`ifdef BP_STATS_EN
    logic [15:0] stat_branches_q, stat_mispred_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            stat_branches_q <= 16'd0;
            stat_mispred_q  <= 16'd0;
        end else begin
            if (qual_res)     stat_branches_q <= sat_inc16(stat_branches_q);
            if (mispredict_d) stat_mispred_q  <= sat_inc16(stat_mispred_q);
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: per-cycle compare against an abstract model plus literal pins.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pred_req = 1'b0;
    logic [31:0] pred_pc = 32'd0;
    logic        res_valid = 1'b0;
    logic [3:0]  res_type = 4'd0;
    logic        res_taken = 1'b0;
    wire         pred_ready, pred_valid, pred_taken, mispredict, correct_taken;
`ifdef BP_STATS_EN
    wire [15:0]  stat_branches, stat_mispred;
`endif

    branch_predictor #(.IDX_W(4), .CTR_W(2)) dut (
        .clk(clk), .nrst(nrst),
        .pred_req(pred_req), .pred_pc(pred_pc), .pred_ready(pred_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_type(res_type), .res_taken(res_taken),
        .mispredict(mispredict), .correct_taken(correct_taken)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Abstract model: counters as plain integers 0..3, predict taken when >= 2.
    int  mctr [16];
    bit  m_busy;
    int  m_pidx;
    bit  m_ppred;
    bit  exp_pv, exp_pt, exp_mp, exp_ct;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and advances the model to what the next edge must produce.
    task automatic step(input bit rst_n, input bit req, input logic [31:0] pc,
                        input bit rv, input logic [3:0] rt, input bit rtk);
        bit qual, ready, acc;
        int ridx;
        @(negedge clk);
        nrst = rst_n; pred_req = req; pred_pc = pc;
        res_valid = rv; res_type = rt; res_taken = rtk;
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mctr[i] = 1;
            m_busy = 0;
            {exp_pv, exp_pt, exp_mp, exp_ct} = 4'b0;
        end else begin
            qual  = m_busy && rv && (rt != 0);
            ready = !m_busy || qual;
            check("pred_ready", pred_ready, ready);
            acc  = req && ready;
            ridx = (pc / 4) % 16;
            exp_mp = qual && (rtk != m_ppred);
            exp_ct = qual && rtk;
            if (qual) begin
                if (rtk) mctr[m_pidx] = (mctr[m_pidx] < 3) ? mctr[m_pidx] + 1 : 3;
                else     mctr[m_pidx] = (mctr[m_pidx] > 0) ? mctr[m_pidx] - 1 : 0;
            end
            exp_pv = acc;
            exp_pt = acc && (mctr[ridx] >= 2);
            if (acc) begin
                m_pidx  = ridx;
                m_ppred = exp_pt;
            end
            if (acc)       m_busy = 1;
            else if (qual) m_busy = 0;
        end
        chk_en = 1'b1;
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            check("pred_valid", pred_valid, exp_pv);
            check("pred_taken", pred_taken, exp_pt);
            check("mispredict", mispredict, exp_mp);
            check("correct_taken", correct_taken, exp_ct);
        end
    end

    // Waits past the edge that ends the current step so outputs can be pinned literally.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        after_edge();
        check("rst_pred_valid", pred_valid, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);

        // Reset defaults: first prediction for 0x10 is not-taken.
        step(1, 1, 32'h10, 0, 0, 0);
        after_edge();
        check("lit_first_valid", pred_valid, 1'b1);
        check("lit_first_taken", pred_taken, 1'b0);

        // Mispredict and training.
        step(1, 0, 0, 1, 4'd1, 1);
        after_edge();
        check("lit_mp1", mispredict, 1'b1);
        check("lit_ct1", correct_taken, 1'b1);
        check_int("model_ctr4_a", mctr[4], 2);
        step(1, 1, 32'h10, 0, 0, 0);
        after_edge();
        check("lit_trained_taken", pred_taken, 1'b1);

        // Saturation: four more taken resolutions, each with a back-to-back request.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h10, 1, 4'd1, 1);
        check_int("model_ctr4_sat", mctr[4], 3);
        step(1, 1, 32'h10, 1, 4'd1, 0);
        after_edge();
        check("lit_sat_mp", mispredict, 1'b1);
        check("lit_sat_ct", correct_taken, 1'b0);
        check("lit_sat_still_taken", pred_taken, 1'b1);

        // Ignored resolution in WAIT_RES (type 0) with a request that must not be accepted.
        step(1, 1, 32'h10, 1, 4'd0, 0);
        after_edge();
        check("lit_ign_mp", mispredict, 1'b0);
        check("lit_ign_valid", pred_valid, 1'b0);
        step(1, 0, 0, 1, 4'd2, 0);
        after_edge();
        check("lit_bne_mp", mispredict, 1'b1);
        check_int("model_ctr4_b", mctr[4], 1);
        // Resolution while IDLE is ignored.
        step(1, 0, 0, 1, 4'd3, 1);
        after_edge();
        check("lit_idle_mp", mispredict, 1'b0);
        check_int("model_ctr4_c", mctr[4], 1);

        // Same-cycle bypass on pc 0x20.
        step(1, 1, 32'h20, 0, 0, 0);
        step(1, 1, 32'h20, 1, 4'd4, 1);
        after_edge();
        check("lit_byp_taken", pred_taken, 1'b1);
        check("lit_byp_mp", mispredict, 1'b1);

        // Reset mid-operation with a resolution present: no mispredict afterwards.
        step(0, 0, 0, 1, 4'd1, 0);
        step(1, 0, 0, 1, 4'd1, 0);
        after_edge();
        check("lit_post_rst_mp", mispredict, 1'b0);

        // Every counter must be 01: one taken resolution flips its prediction to taken.
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 32'(i * 4), 0, 0, 0);
            step(1, 1, 32'(i * 4), 1, 4'd1, 1);
            step(1, 0, 0, 1, 4'd1, 0);
        end

        // Aliasing: 0x40 and 0x00 share index 0.
        step(1, 1, 32'h40, 0, 0, 0);
        step(1, 1, 32'h00, 1, 4'd1, 1);
        after_edge();
        check("lit_alias_taken", pred_taken, 1'b1);
        step(1, 0, 0, 1, 4'd1, 0);
        step(1, 0, 0, 0, 0, 0);
        after_edge();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
